// File: rtl/alu4_seq_if.sv
// Host command/response channel of alu4_seq: valid/ready command in, valid/ready response out.
interface alu4_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;

    modport master (
        output cmd_valid, cmd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu4_seq.sv
// 4x4-bit register file sequencer driving an external combinational ALU; macro ALU4_SEQ_FLAGCHAIN_EN feeds stored C/R back as carry-ins.
// Latency: LOADI/READ/CLRF respond 1 cycle after accept, EXEC 2 cycles (operands registered, then result captured).
// Backpressure: one command in flight; cmd_ready only in IDLE with ena, response held until rsp_ready.
module alu4_seq #(
    parameter int NREG = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    alu4_seq_if.slave  host,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_cin,
    output logic       alu_rcin,
    input  logic [3:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_rc,
    input  logic       alu_z,
    input  logic       alu_v
);
    localparam logic [1:0] T_EXEC  = 2'b00;
    localparam logic [1:0] T_LOADI = 2'b01;
    localparam logic [1:0] T_READ  = 2'b10;
    localparam logic [1:0] T_CLRF  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state;
    logic [3:0] regs [NREG];
    logic [3:0] flags;          // {V, Z, R, C}
    logic [1:0] rd_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    logic [1:0] cmd_type;
    logic [3:0] cmd_imm;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic       unused_rsvd;

    assign cmd_type    = host.cmd[13:12];
    assign cmd_imm     = host.cmd[11:8];
    assign cmd_rd      = host.cmd[7:6];
    assign cmd_rs1     = host.cmd[5:4];
    assign cmd_rs2     = host.cmd[3:2];
    assign unused_rsvd = ^host.cmd[1:0];

    assign host.cmd_ready = ena && (state == IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;

`ifdef ALU4_SEQ_FLAGCHAIN_EN
    assign alu_cin  = flags[0];
    assign alu_rcin = flags[1];
`else
    assign alu_cin  = 1'b0;
    assign alu_rcin = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flags       <= 4'h0;
            rd_q        <= 2'b00;
            alu_a       <= 4'h0;
            alu_b       <= 4'h0;
            alu_op      <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 4'h0;
            end
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (host.cmd_valid) begin
                        case (cmd_type)
                            T_EXEC: begin
                                // Operands latch before the write-back, so rd==rs reads the old value.
                                alu_a  <= regs[cmd_rs1];
                                alu_b  <= regs[cmd_rs2];
                                alu_op <= cmd_imm;
                                rd_q   <= cmd_rd;
                                state  <= ISSUE;
                            end
                            T_LOADI: begin
                                regs[cmd_rd] <= cmd_imm;
                                rsp_data_q   <= {flags, cmd_imm};
                                rsp_valid_q  <= 1'b1;
                                state        <= RESP;
                            end
                            T_READ: begin
                                rsp_data_q  <= {flags, regs[cmd_rs1]};
                                rsp_valid_q <= 1'b1;
                                state       <= RESP;
                            end
                            T_CLRF: begin
                                flags       <= 4'h0;
                                rsp_data_q  <= 8'h00;
                                rsp_valid_q <= 1'b1;
                                state       <= RESP;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                ISSUE: begin
                    regs[rd_q]  <= alu_out;
                    flags       <= {alu_v, alu_z, alu_rc, alu_c};
                    rsp_data_q  <= {alu_v, alu_z, alu_rc, alu_c, alu_out};
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu4_seq.md
ALU4_SEQ -- requirements
Module: alu4_seq

Interface
REQ-001 Parameter NREG, default 4, number of 4-bit registers in the register file; legal value 4 only; register index fields are 2 bits.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 ena  in  1  clock-enable; when low, all state holds.
REQ-005 cmd_valid  in  1  host command valid.
REQ-006 cmd_ready  out  1  block accepts a command this cycle.
REQ-007 cmd  in  14  command word: [13:12] type, [11:8] op/imm, [7:6] rd, [5:4] rs1, [3:2] rs2, [1:0] reserved and ignored.
REQ-008 rsp_valid  out  1  response valid.
REQ-009 rsp_ready  in  1  host accepts the response.
REQ-010 rsp_data  out  8  response: [7] V, [6] Z, [5] R, [4] C, [3:0] value.
REQ-011 alu_a, alu_b  out  4 each  registered operands to the downstream combinational ALU.
REQ-012 alu_op  out  4  registered ALU opcode.
REQ-013 alu_cin, alu_rcin  out  1 each  math carry-in and rotate carry-in to the ALU.
REQ-014 alu_out  in  4  ALU result.
REQ-015 alu_c, alu_rc, alu_z, alu_v  in  1 each  ALU math carry, rotate carry, zero and overflow flags.

Function
REQ-016 Command types: 00 EXEC, 01 LOADI, 10 READ, 11 CLRF.
REQ-017 FSM states: IDLE, ISSUE, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE with ena=1; a command is accepted on a cycle with cmd_valid & cmd_ready.
REQ-019 EXEC accepted at edge N: at that edge alu_a<=reg[rs1], alu_b<=reg[rs2], alu_op<=op; state goes to ISSUE.
REQ-020 ISSUE edge: reg[rd]<=alu_out; {V,Z,R,C}<={alu_v,alu_z,alu_rc,alu_c}; rsp_data<={flags_new, alu_out}; rsp_valid<=1; state goes to RESP. EXEC latency is 2 cycles from acceptance to rsp_valid.
REQ-021 LOADI accepted: reg[rd]<=imm; flags unchanged; rsp_data<={flags, imm}; rsp_valid<=1; state goes to RESP. Latency is 1 cycle.
REQ-022 READ accepted: rsp_data<={flags, reg[rs1]}; state and registers unchanged apart from rsp; state goes to RESP. Latency is 1 cycle.
REQ-023 CLRF accepted: all four flags<=0; rsp_data<=8'h00; state goes to RESP. Latency is 1 cycle.
REQ-024 In RESP, rsp_valid and rsp_data SHALL hold stable until rsp_valid & rsp_ready; on that edge rsp_valid<=0 and state goes to IDLE.
REQ-025 At most one command is in flight; there is no back-to-back overlap. Minimum command period is 2 cycles for LOADI, READ and CLRF, and 3 cycles for EXEC.
REQ-026 rd equal to rs1 or rs2 SHALL use the old operand value; the write occurs after the operand is registered.
REQ-027 alu_a, alu_b and alu_op SHALL hold their last issued value outside ISSUE.
REQ-028 ena=0 SHALL freeze the state, registers, flags and outputs; cmd_ready=0; handshakes are ignored.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, all registers 0, flags 0, alu_a/alu_b/alu_op 0, rsp_valid 0, rsp_data 0.
REQ-030 Reset during ISSUE or RESP SHALL abandon the command, with no register or flag write; the first accept is possible on the first enabled edge after release.

Configuration
REQ-031 Macro ALU4_SEQ_FLAGCHAIN_EN. Defined: alu_cin=C and alu_rcin=R (stored flags), enabling multi-nibble chains. Undefined: alu_cin=0, alu_rcin=0, and flags have no effect on ALU inputs.

Verification
REQ-032 Reset, then LOADI rd=1 imm=9 -> rsp_data=0x09 one cycle after accept; READ rs1=1 -> 0x09.
REQ-033 r1=9, r2=8; EXEC op=0x3 rd=3 rs1=1 rs2=2; stub drives alu_out=1, c=1, rc=0, z=0, v=1 -> alu_a=9, alu_b=8, alu_op=3 in ISSUE; rsp_data=0x91 two cycles after accept; READ r3 -> 0x91.
REQ-034 Response stall: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; accept resumes the cycle after the handshake.
REQ-035 With the macro defined, after the REQ-033 scenario -> alu_cin=1, alu_rcin=0; after CLRF -> alu_cin=0, rsp_data=0x00. With the macro undefined -> alu_cin=0 always.
REQ-036 Assert rst_n=0 in ISSUE of an EXEC targeting r3 -> r3 stays 0, rsp_valid=0; ena=0 with cmd_valid=1 -> no accept.
